decode_stage: RTL and testbench

- Pipelined successor to the single-cycle instruction decoder.
- Contains the register file, control decode and immediate generation, with an ID/EX output register.
- Adds valid tracking, load-use stall detection, flush, and a parametrised register count (RV32I/RV32E).
- Sits between the fetch-stage IF/ID register and the execute stage; branch resolution moves to EX.

---
 rtl/decode_pkg.sv | 47 ++++
 rtl/decode_regfile.sv | 48 ++++
 rtl/decode_stage.sv | 209 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate formats, ALU codes and the EX control bundle.
package decode_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;

  // ALU code is {instr[30], funct3} for register/immediate ops; the fixed codes below cover the rest.
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       result_src;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       jret;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_src_t src);
    case (src)
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return {{20{instr[31]}}, instr[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file: x0 hardwired to zero, indices >= REG_COUNT read 0 and are never written.
// DECODE_WB_BYPASS_EN makes a same-cycle writeback visible on the read ports and a0.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_IDX_W-1:0]  rs1,
  input  logic [REG_IDX_W-1:0]  rs2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic                  we,
  input  logic [REG_IDX_W-1:0]  wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int AW = $clog2(REG_COUNT);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  wr_ok;

  assign wr_ok = we && (wr_idx != '0) && (int'(wr_idx) < REG_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_idx[AW-1:0]] <= wr_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read(input logic [REG_IDX_W-1:0] idx);
    if (idx == '0 || int'(idx) >= REG_COUNT) return '0;
`ifdef DECODE_WB_BYPASS_EN
    if (wr_ok && idx == wr_idx) return wr_data;
`endif
    return regs[idx[AW-1:0]];
  endfunction

  assign rd1 = read(rs1);
  assign rd2 = read(rs2);
  assign a0  = read(REG_IDX_W'(10));

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: regfile, control/immediate decode, load-use stall, flush and ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN enables writeback write-through inside decode_regfile.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid_i,
  input  logic [31:0]           if_instr_i,
  input  logic [DATA_WIDTH-1:0] if_pc_i,
  output logic                  id_ready_o,
  input  logic                  flush_i,
  input  logic                  wb_we_i,
  input  logic [4:0]            wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  ex_valid_o,
  output logic [DATA_WIDTH-1:0] ex_pc_o,
  output logic [DATA_WIDTH-1:0] ex_rd1_o,
  output logic [DATA_WIDTH-1:0] ex_rd2_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [4:0]            ex_rs1_o,
  output logic [4:0]            ex_rs2_o,
  output logic [4:0]            ex_rd_o,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_result_src_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic                  ex_jret_o,
  output logic [2:0]            ex_funct3_o,
  output logic                  ex_illegal_o,
  output logic [DATA_WIDTH-1:0] a0_o
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [4:0]            rs1, rs2, rd;
  logic [DATA_WIDTH-1:0] rd1, rd2, imm;
  ctrl_t                 ctrl, ex_ctrl;
  imm_src_t              imm_src;
  logic                  has_imm, known, use_rs1, use_rs2, bad_idx, illegal;
  logic                  load_use, stall, take;

  assign opcode = if_instr_i[6:0];
  assign funct3 = if_instr_i[14:12];
  assign rs1    = if_instr_i[19:15];
  assign rs2    = if_instr_i[24:20];
  assign rd     = if_instr_i[11:7];

  decode_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd1     (rd1),
    .rd2     (rd2),
    .we      (wb_we_i),
    .wr_idx  (wb_rd_i),
    .wr_data (wb_data_i),
    .a0      (a0_o)
  );

  always_comb begin
    ctrl    = CTRL_NOP;
    imm_src = IMM_I;
    has_imm = 1'b1;
    known   = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.alu_ctrl  = {if_instr_i[30], funct3};
        ctrl.reg_write = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        has_imm        = 1'b0;
      end
      OP_I: begin
        // instr[30] only distinguishes SRAI from SRLI; for other I-ops it is immediate data.
        ctrl.alu_ctrl  = (funct3 == 3'b101) ? {if_instr_i[30], funct3} : {1'b0, funct3};
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        use_rs1        = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        use_rs1         = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        imm_src        = IMM_S;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.branch   = 1'b1;
        imm_src       = IMM_B;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_JAL: begin
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        imm_src        = IMM_J;
      end
      OP_JALR: begin
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.jret      = 1'b1;
        ctrl.reg_write = 1'b1;
        use_rs1        = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_ctrl  = ALU_PASSB;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        imm_src        = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        imm_src        = IMM_U;
      end
      default: begin
        known   = 1'b0;
        has_imm = 1'b0;
      end
    endcase

    // RV32E: a set bit 4 is reported, never folded onto x0..x15.
    bad_idx = (use_rs1 && int'(rs1) >= REG_COUNT) ||
              (use_rs2 && int'(rs2) >= REG_COUNT) ||
              (ctrl.reg_write && int'(rd) >= REG_COUNT);
    illegal = !known || bad_idx;
    if (illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
      ctrl.jret      = 1'b0;
    end
  end

  assign imm = has_imm ? DATA_WIDTH'($signed(gen_imm(if_instr_i, imm_src))) : '0;

  assign load_use = ex_valid_o && ex_mem_read_o && (ex_rd_o != '0) &&
                    ((use_rs1 && ex_rd_o == rs1) || (use_rs2 && ex_rd_o == rs2));
  assign stall      = if_valid_i && load_use && !flush_i;
  assign id_ready_o = rst || !stall;
  assign take       = if_valid_i && !flush_i && !stall;

  always_ff @(posedge clk) begin
    if (rst || !take) begin
      ex_valid_o   <= 1'b0;
      ex_pc_o      <= '0;
      ex_rd1_o     <= '0;
      ex_rd2_o     <= '0;
      ex_imm_o     <= '0;
      ex_rs1_o     <= '0;
      ex_rs2_o     <= '0;
      ex_rd_o      <= '0;
      ex_ctrl      <= CTRL_NOP;
      ex_funct3_o  <= '0;
      ex_illegal_o <= 1'b0;
    end else begin
      ex_valid_o   <= 1'b1;
      ex_pc_o      <= if_pc_i;
      ex_rd1_o     <= rd1;
      ex_rd2_o     <= rd2;
      ex_imm_o     <= imm;
      ex_rs1_o     <= rs1;
      ex_rs2_o     <= rs2;
      ex_rd_o      <= rd;
      ex_ctrl      <= ctrl;
      ex_funct3_o  <= funct3;
      ex_illegal_o <= illegal;
    end
  end

  assign ex_alu_ctrl_o   = ALU_CTRL_W'(ex_ctrl.alu_ctrl);
  assign ex_alu_src_o    = ex_ctrl.alu_src;
  assign ex_result_src_o = ex_ctrl.result_src;
  assign ex_mem_write_o  = ex_ctrl.mem_write;
  assign ex_mem_read_o   = ex_ctrl.mem_read;
  assign ex_reg_write_o  = ex_ctrl.reg_write;
  assign ex_branch_o     = ex_ctrl.branch;
  assign ex_jump_o       = ex_ctrl.jump;
  assign ex_jret_o       = ex_ctrl.jret;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized stimulus against a reference model.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_valid, flush, wb_we, id_ready;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        ex_valid, ex_alu_src, ex_result_src, ex_mem_write, ex_mem_read, ex_reg_write;
  logic        ex_branch, ex_jump, ex_jret, ex_illegal;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm, a0;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_ctrl;
  logic [2:0]  ex_funct3;

  logic        rve_valid, rve_flush, rve_we, rve_ready;
  logic [31:0] rve_instr, rve_pc, rve_data;
  logic [4:0]  rve_wrd;
  logic        rve_ex_valid, rve_alu_src, rve_result_src, rve_mem_write, rve_mem_read, rve_reg_write;
  logic        rve_branch, rve_jump, rve_jret, rve_illegal;
  logic [31:0] rve_ex_pc, rve_ex_rd1, rve_ex_rd2, rve_ex_imm, rve_a0;
  logic [4:0]  rve_ex_rs1, rve_ex_rs2, rve_ex_rd;
  logic [3:0]  rve_alu_ctrl;
  logic [2:0]  rve_funct3;

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc_i(if_pc),
    .id_ready_o(id_ready), .flush_i(flush), .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rd1_o(ex_rd1), .ex_rd2_o(ex_rd2), .ex_imm_o(ex_imm),
    .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_alu_ctrl_o(ex_alu_ctrl),
    .ex_alu_src_o(ex_alu_src), .ex_result_src_o(ex_result_src), .ex_mem_write_o(ex_mem_write),
    .ex_mem_read_o(ex_mem_read), .ex_reg_write_o(ex_reg_write), .ex_branch_o(ex_branch),
    .ex_jump_o(ex_jump), .ex_jret_o(ex_jret), .ex_funct3_o(ex_funct3), .ex_illegal_o(ex_illegal),
    .a0_o(a0)
  );

  decode_stage #(.REG_COUNT(16)) dut_rve (
    .clk(clk), .rst(rst), .if_valid_i(rve_valid), .if_instr_i(rve_instr), .if_pc_i(rve_pc),
    .id_ready_o(rve_ready), .flush_i(rve_flush), .wb_we_i(rve_we), .wb_rd_i(rve_wrd), .wb_data_i(rve_data),
    .ex_valid_o(rve_ex_valid), .ex_pc_o(rve_ex_pc), .ex_rd1_o(rve_ex_rd1), .ex_rd2_o(rve_ex_rd2),
    .ex_imm_o(rve_ex_imm), .ex_rs1_o(rve_ex_rs1), .ex_rs2_o(rve_ex_rs2), .ex_rd_o(rve_ex_rd),
    .ex_alu_ctrl_o(rve_alu_ctrl), .ex_alu_src_o(rve_alu_src), .ex_result_src_o(rve_result_src),
    .ex_mem_write_o(rve_mem_write), .ex_mem_read_o(rve_mem_read), .ex_reg_write_o(rve_reg_write),
    .ex_branch_o(rve_branch), .ex_jump_o(rve_jump), .ex_jret_o(rve_jret), .ex_funct3_o(rve_funct3),
    .ex_illegal_o(rve_illegal), .a0_o(rve_a0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: architectural registers and the expected ID/EX contents.
  logic [31:0] m_regs [32];
  logic        exp_valid, exp_ill, exp_mr;
  logic [31:0] exp_pc, exp_rd1, exp_rd2, exp_imm;
  logic [4:0]  exp_rs1, exp_rs2, exp_rd;
  logic [11:0] exp_ctrl;
  logic [2:0]  exp_f3;
  logic        seen_ready;

  typedef struct packed {
    logic        legal;
    logic        u1;
    logic        u2;
    logic [11:0] ctrl;
    logic [31:0] imm;
  } dec_t;

  // ctrl order: {alu[3:0], alu_src, result_src, mem_write, mem_read, reg_write, branch, jump, jret}
  function automatic dec_t ref_decode(input logic [31:0] ins, input int rc);
    dec_t d;
    logic [3:0] alu;
    logic src, res, mw, mr, rw, br, j, jr;
    d = '0;
    alu = 4'd0;
    {src, res, mw, mr, rw, br, j, jr} = 8'b0;
    d.legal = 1'b1;
    case (ins[6:0])
      7'h33: begin alu = 4'((ins[30] ? 8 : 0) + int'(ins[14:12])); rw = 1; d.u1 = 1; d.u2 = 1; end
      7'h13: begin
        alu = 4'(((ins[14:12] == 3'd5 && ins[30]) ? 8 : 0) + int'(ins[14:12]));
        src = 1; rw = 1; d.u1 = 1; d.imm = 32'($signed(ins[31:20]));
      end
      7'h03: begin src = 1; res = 1; mr = 1; rw = 1; d.u1 = 1; d.imm = 32'($signed(ins[31:20])); end
      7'h23: begin src = 1; mw = 1; d.u1 = 1; d.u2 = 1; d.imm = 32'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin
        alu = 4'd8; br = 1; d.u1 = 1; d.u2 = 1;
        d.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'h6f: begin j = 1; rw = 1; d.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      7'h67: begin src = 1; jr = 1; rw = 1; d.u1 = 1; d.imm = 32'($signed(ins[31:20])); end
      7'h37: begin alu = 4'd15; src = 1; rw = 1; d.imm = {ins[31:12], 12'b0}; end
      7'h17: begin src = 1; rw = 1; d.imm = {ins[31:12], 12'b0}; end
      default: d.legal = 1'b0;
    endcase
    if ((d.u1 && int'(ins[19:15]) >= rc) || (d.u2 && int'(ins[24:20]) >= rc) || (rw && int'(ins[11:7]) >= rc))
      d.legal = 1'b0;
    if (!d.legal) {mw, rw, br, j, jr} = 5'b0;
    d.ctrl = {alu, src, res, mw, mr, rw, br, j, jr};
    return d;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_we && idx == wb_rd) return wb_data;
`endif
    return m_regs[idx];
  endfunction

  task automatic clear_exp();
    exp_valid = 0; exp_ill = 0; exp_mr = 0;
    exp_pc = 0; exp_rd1 = 0; exp_rd2 = 0; exp_imm = 0;
    exp_rs1 = 0; exp_rs2 = 0; exp_rd = 0; exp_ctrl = 0; exp_f3 = 0;
  endtask

  task automatic compare_ex();
    check("ex_valid", 64'(ex_valid), 64'(exp_valid));
    check("ex_pc", 64'(ex_pc), 64'(exp_pc));
    check("ex_rd1", 64'(ex_rd1), 64'(exp_rd1));
    check("ex_rd2", 64'(ex_rd2), 64'(exp_rd2));
    check("ex_imm", 64'(ex_imm), 64'(exp_imm));
    check("ex_idx", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({exp_rs1, exp_rs2, exp_rd}));
    check("ex_ctrl", 64'({ex_alu_ctrl, ex_alu_src, ex_result_src, ex_mem_write, ex_mem_read,
                          ex_reg_write, ex_branch, ex_jump, ex_jret}), 64'(exp_ctrl));
    check("ex_funct3", 64'(ex_funct3), 64'(exp_f3));
    check("ex_illegal", 64'(ex_illegal), 64'(exp_ill));
    check("a0", 64'(a0), 64'(m_regs[10]));
  endtask

  // One cycle: drive inputs just after a rising edge, check id_ready mid-cycle, check ID/EX after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    dec_t d;
    logic stall, take;
    logic [31:0] r1v, r2v;
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    @(negedge clk);
    d = ref_decode(ins, 32);
    stall = v && !fl && exp_valid && exp_mr && exp_rd != 5'd0 &&
            ((d.u1 && exp_rd == ins[19:15]) || (d.u2 && exp_rd == ins[24:20]));
    take = v && !fl && !stall;
    seen_ready = id_ready;
    check("id_ready", 64'(id_ready), 64'(!stall));
    r1v = ref_read(ins[19:15]);
    r2v = ref_read(ins[24:20]);
    @(posedge clk);
    #1;
    if (we && wrd != 5'd0) m_regs[wrd] = wd;
    if (take) begin
      exp_valid = 1; exp_pc = pc; exp_rd1 = r1v; exp_rd2 = r2v; exp_imm = d.imm;
      exp_rs1 = ins[19:15]; exp_rs2 = ins[24:20]; exp_rd = ins[11:7];
      exp_ctrl = d.ctrl; exp_mr = d.ctrl[4]; exp_f3 = ins[14:12]; exp_ill = !d.legal;
    end else begin
      clear_exp();
    end
    compare_ex();
  endtask

  localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63,
                                      7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    r[6:0]   = OPS[$urandom_range(10)];
    r[11:7]  = 5'($urandom_range(7));
    r[19:15] = 5'($urandom_range(7));
    r[24:20] = 5'($urandom_range(7));
    return r;
  endfunction

`ifdef DECODE_WB_BYPASS_EN
  localparam logic [31:0] BYPASS_EXP = 32'h0000DEAD;
`else
  localparam logic [31:0] BYPASS_EXP = 32'h00001111;
`endif

  localparam logic [31:0] I_ADDI  = 32'h00500513;  // addi x10,x0,5
  localparam logic [31:0] I_LW    = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] I_ADD   = 32'h00728333;  // add x6,x5,x7
  localparam logic [31:0] I_BYP   = 32'h00018233;  // add x4,x3,x0

  logic        cv;
  logic [31:0] ci, cpc;
  logic [4:0]  rwrd;

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    clear_exp();
    rve_valid = 0; rve_flush = 0; rve_we = 0; rve_instr = 0; rve_pc = 0; rve_data = 0; rve_wrd = 0;

    // Reset with live inputs, a pending flush and a writeback to x10: reset must win.
    rst = 1; if_valid = 1; if_instr = I_ADDI; if_pc = 32'h40; flush = 1;
    wb_we = 1; wb_rd = 5'd10; wb_data = 32'd77;
    repeat (2) begin
      @(negedge clk);
      check("ready_in_rst", 64'(id_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    compare_ex();
    rst = 0;

    step(1, I_ADDI, 32'h100, 0, 0, 5'd0, 0);
    check("addi_imm", 64'(ex_imm), 64'd5);
    check("addi_src_rw", 64'({ex_alu_src, ex_reg_write}), 64'b11);
    check("addi_rd", 64'(ex_rd), 64'd10);
    step(0, 0, 0, 0, 1, 5'd10, 32'd5);
    check("a0_after_wb", 64'(a0), 64'd5);

    step(1, I_LW, 32'h200, 0, 0, 5'd0, 0);
    step(1, I_ADD, 32'h204, 0, 0, 5'd0, 0);
    check("lu_stall_ready", 64'(seen_ready), 64'd0);
    check("lu_bubble", 64'(ex_valid), 64'd0);
    step(1, I_ADD, 32'h204, 0, 0, 5'd0, 0);
    check("lu_issue_ready", 64'(seen_ready), 64'd1);
    check("lu_issue_valid", 64'(ex_valid), 64'd1);

    step(1, I_LW, 32'h300, 0, 0, 5'd0, 0);
    step(1, I_ADD, 32'h304, 1, 0, 5'd0, 0);
    check("flush_ready", 64'(seen_ready), 64'd1);
    check("flush_bubble", 64'(ex_valid), 64'd0);
    step(1, I_ADD, 32'h308, 0, 0, 5'd0, 0);
    check("post_flush_ready", 64'(seen_ready), 64'd1);

    step(0, 0, 0, 0, 1, 5'd3, 32'h1111);
    step(1, I_BYP, 32'h400, 0, 1, 5'd3, 32'hDEAD);
    check("bypass_rd1", 64'(ex_rd1), 64'(BYPASS_EXP));

    // RV32E instance: x0 stays zero, x10 reachable, bit-4 indices flagged illegal.
    rve_we = 1; rve_wrd = 5'd0; rve_data = 32'h99;
    @(posedge clk); #1;
    rve_wrd = 5'd10; rve_data = 32'h55;
    @(posedge clk); #1;
    rve_we = 0; rve_valid = 1; rve_instr = 32'h000000B3;  // add x1,x0,x0
    @(posedge clk); #1;
    check("rve_x0", 64'(rve_ex_rd1), 64'd0);
    check("rve_a0", 64'(rve_a0), 64'h55);
    check("rve_legal", 64'({rve_ex_valid, rve_illegal, rve_reg_write}), 64'b101);
    rve_instr = 32'h002088B3;  // add x17,x1,x2
    @(posedge clk); #1;
    check("rve_bad_rd", 64'({rve_ex_valid, rve_illegal, rve_reg_write}), 64'b110);
    rve_instr = 32'h014080B3;  // add x1,x1,x20
    @(posedge clk); #1;
    check("rve_bad_rs2", 64'({rve_ex_valid, rve_illegal, rve_reg_write}), 64'b110);
    rve_valid = 0;

    // Randomized traffic; a stalled instruction is held by upstream until accepted.
    seen_ready = 1;
    for (int n = 0; n < 600; n++) begin
      if (seen_ready) begin
        cv  = ($urandom_range(99) < 85);
        ci  = rand_instr();
        cpc = $urandom & 32'hFFFF_FFFC;
      end
      rwrd = ($urandom_range(1) == 1) ? 5'($urandom_range(7)) : 5'($urandom_range(31));
      step(cv, ci, cpc, ($urandom_range(99) < 8), 1'($urandom_range(1)), rwrd, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
